mp_add_seq: RTL and testbench
=============================

MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 NWORDS, 4, number of 32-bit words per operand; legal range 2..8.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 start  input  1  operation request; sampled only in IDLE or DONE.
REQ-005 a_in  input  32*NWORDS  operand A, unsigned.
REQ-006 b_in  input  32*NWORDS  operand B, unsigned.
REQ-007 cin  input  1  carry into word 0.
REQ-008 busy  output  1  high while in ADD.
REQ-009 done  output  1  one-cycle pulse: sum_out and cout are valid.
REQ-010 sum_out  output  32*NWORDS  result; held until the next completion.
REQ-011 cout  output  1  carry out of word NWORDS-1; held with sum_out.

Function
REQ-012 States SHALL be IDLE, ADD and DONE; all outputs SHALL be registered.
REQ-013 On start in IDLE or DONE, the block SHALL capture a_in, b_in and cin into operand registers at that edge, clear the word index, and enter ADD.
REQ-014 Input changes after capture SHALL have no effect on the operation in progress.
REQ-015 Each ADD cycle SHALL add A word[idx] + B word[idx] + carry register through one 32-bit adder instance.
- Sum word is written to the staging register; carry register receives adder carry-out; idx increments.
REQ-016 On the edge that writes word NWORDS-1:
- the block enters DONE;
- staging SHALL transfer to sum_out and the final carry to cout;
- done=1 for exactly one cycle.
REQ-017 Latency SHALL be NWORDS cycles from the start-sampling edge to done high.
REQ-018 A start in DONE SHALL be accepted back-to-back, giving throughput of one operation per NWORDS+1 cycles.
REQ-019 DONE without start SHALL return to IDLE.
REQ-020 Start during ADD SHALL be ignored, with no queueing.
REQ-021 Arithmetic SHALL be modulo 2^(32*NWORDS); overflow is reported only through cout.
- Example: all-ones + 0 + cin=1 gives sum_out=0, cout=1.
REQ-022 sum_out and cout SHALL NOT change during ADD; they always show the last completed result.

Reset
REQ-023 rst_n low SHALL, immediately and regardless of clk:
- force state to IDLE;
- clear idx, carry, operand and staging registers;
- set busy=0, done=0, sum_out=0, cout=0.
REQ-024 Reset during ADD SHALL abort the operation with no done pulse.
REQ-025 The first start after rst_n deasserts SHALL complete normally.

Configuration
REQ-026 Macro MP_ADD_SAT_EN defined: a completing operation with final carry 1 SHALL load sum_out with all ones; cout still reports 1.
REQ-027 MP_ADD_SAT_EN undefined: sum_out SHALL be the modular result per REQ-021; no saturation logic is present.

Structure
REQ-028 Package mp_add_pkg SHALL hold:
- WORD_W=32;
- the state enum type (IDLE, ADD, DONE);
- the index-width constant derived from NWORDS maximum 8.
REQ-029 Sub-module adder32_df SHALL be instantiated exactly once.
- Behaviour: combinational 32-bit add; inputs a, b, ci; outputs s, co.

Verification
REQ-030 NWORDS=4, A=16, B=11, cin=0 -> done 4 cycles after start; sum_out=27, cout=0; busy high for exactly 4 cycles.
REQ-031 A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1 -> sum_out=0x1_0000_0000, showing carry across words; cout=0.
REQ-032 A=all ones, B=0, cin=1:
- without MP_ADD_SAT_EN -> sum_out=0, cout=1;
- with MP_ADD_SAT_EN -> sum_out=all ones, cout=1.
REQ-033 Start(A=25, B=12); start(A=3, B=3) asserted during ADD -> single done, sum_out=37; then start held in DONE with A=3, B=3 -> next done exactly NWORDS+1 cycles after the first, sum_out=6.
REQ-034 Reset sequence:
- start(A=5, B=7), then rst_n low after 2 ADD cycles -> busy, done, sum_out and cout go to 0 without a clock edge, with no done pulse;
- after release, start(A=5, B=7) -> sum_out=12.

Source files
------------

// File: rtl/mp_add_pkg.sv
// mp_add_pkg -- shared constants and types for the sequential multi-word adder.
//   WORD_W     : width of one operand word (the adder slice width).
//   MAX_NWORDS : largest supported word count; sizes the word index.
//   IDX_W      : word-index register width.
//   state_t    : controller states IDLE / ADD / DONE.
package mp_add_pkg;

  localparam int WORD_W     = 32;
  localparam int MAX_NWORDS = 8;
  localparam int IDX_W      = $clog2(MAX_NWORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder32_df.sv
// adder32_df -- combinational one-word adder used once per ADD cycle.
// Ports:
//   a, b : input  [WORD_W-1:0] addends
//   ci   : input  carry in
//   s    : output [WORD_W-1:0] sum
//   co   : output carry out
module adder32_df
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, ci};

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq -- word-serial unsigned adder of two NWORDS x 32-bit operands.
// One word is added per clock through a single adder32_df; the result is
// published to sum_out/cout on the edge that adds the top word.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request, accepted in IDLE or DONE only
//   a_in, b_in, cin   : operands and carry into word 0 (captured on start)
//   busy              : high while adding
//   done              : one-cycle pulse when sum_out/cout update
//   sum_out, cout     : last completed result, held between operations
// Build option: define MP_ADD_SAT_EN to saturate sum_out to all ones when the
// final carry is 1 (cout still reports the carry).
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int NWORDS = 4  // legal range 2..8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WORD_W*NWORDS-1:0] a_in,
  input  logic [WORD_W*NWORDS-1:0] b_in,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_W*NWORDS-1:0] sum_out,
  output logic                     cout
);

  localparam int W = WORD_W * NWORDS;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     stage_q, stage_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WORD_W-1:0] a_word, b_word, s_word;
  logic              co_word;
  logic              last_word;

  // Select the operand words addressed by the current index.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_word = a_q[i*WORD_W +: WORD_W];
        b_word = b_q[i*WORD_W +: WORD_W];
      end
    end
  end

  assign last_word = (idx_q == IDX_W'(NWORDS - 1));

  adder32_df u_add (
    .a  (a_word),
    .b  (b_word),
    .ci (carry_q),
    .s  (s_word),
    .co (co_word)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    stage_d = stage_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          state_d = ADD;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      ADD: begin
        for (int i = 0; i < NWORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            stage_d[i*WORD_W +: WORD_W] = s_word;
          end
        end
        carry_d = co_word;
        idx_d   = idx_q + 1'b1;
        if (last_word) begin
          // Publish the staging value including the word written this edge.
          state_d = DONE;
          done_d  = 1'b1;
          cout_d  = co_word;
`ifdef MP_ADD_SAT_EN
          sum_d   = co_word ? '1 : stage_d;
`else
          sum_d   = stage_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ADD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      stage_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq -- scoreboard bench for mp_add_seq (NWORDS = 4).
// Stimulus pushes the hand-computed result and its expected done cycle; an
// independent monitor pops and compares whenever done is seen.
module tb_mp_add_seq;

  localparam int N = 4;
  localparam int W = 32 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum_out;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mp_add_seq #(.NWORDS(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      $display("[TB] ok %s = %h", nm, act);
    end
  endtask

  // Monitor: scoreboard compare on done, output stability while busy.
  int           busy_cnt = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_c = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      last_sum = '0;
      last_c   = 1'b0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", W'(1), W'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum_out", sum_out, e.sum);
          chk("cout", W'(cout), W'(e.c));
          chk("done_cycle", W'(cyc), W'(e.cyc));
          chk("busy_cycles", W'(busy_cnt), W'(N));
        end
        busy_cnt = 0;
        last_sum = sum_out;
        last_c   = cout;
      end
      if (busy) begin
        busy_cnt++;
        chk("hold_during_add", {sum_out[W-2:0], cout}, {last_sum[W-2:0], last_c});
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("done_timeout", W'(q.size()), W'(0));
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] es, input logic ec);
    exp_t e;
    @(negedge clk);
    a_in = a; b_in = b; cin = ci; start = 1'b1;
    e.sum = es; e.c = ec; e.cyc = cyc + 1 + N;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs after capture; the operation must be unaffected.
    a_in = '1; b_in = '1; cin = 1'b1;
    drain();
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] sat_exp;
`ifdef MP_ADD_SAT_EN
    sat_exp = '1;
`else
    sat_exp = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_sum", sum_out, W'(0));
    chk("rst_cout", W'(cout), W'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(W'(16), W'(11), 1'b0, W'(27), 1'b0);
    run_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, W'(64'h1_0000_0000), 1'b0);
    run_op('1, W'(0), 1'b1, sat_exp, 1'b1);
    run_op(W'(7), W'(9), 1'b1, W'(17), 1'b0);

    // Start ignored during ADD, then held into DONE for a back-to-back op.
    @(negedge clk);
    a_in = W'(25); b_in = W'(12); cin = 1'b0; start = 1'b1;
    e.sum = W'(37); e.c = 1'b0; e.cyc = cyc + 1 + N;
    q.push_back(e);
    e.sum = W'(6); e.c = 1'b0; e.cyc = cyc + 2 + 2 * N;
    q.push_back(e);
    @(negedge clk);
    a_in = W'(3); b_in = W'(3);
    repeat (N + 1) @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset mid-operation: outputs clear without a clock edge.
    @(negedge clk);
    a_in = W'(5); b_in = W'(7); cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_done", W'(done), W'(0));
    chk("arst_sum", sum_out, W'(0));
    chk("arst_cout", W'(cout), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    run_op(W'(5), W'(7), 1'b0, W'(12), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
